// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: opcode constants, the canonical NOP and the fetch-stage state type.
// Also imported by the multicycle controller so both stages decode opcodes the same way.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_WAIT,
    F_HOLD
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and the memory (slave).
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
) ();

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;

  modport master (output mem_rd, mem_addr, input mem_rdata, mem_rvalid);
  modport slave  (input mem_rd, mem_addr, output mem_rdata, mem_rvalid);

endinterface

// File: rtl/instr_fetch_unit_imm_gen.sv
// Immediate generator: picks the RV32 immediate format from the opcode and sign-extends it.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (ir[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:                 imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:                imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {ir[31:12], 12'b0};
      OP_JAL:                   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:                  imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads one word per fetch_go and holds it in IR until instr_ack.
// Define FETCH_TIMEOUT_EN to abandon a fetch after TIMEOUT_CYC wait cycles and flag fetch_err.
module instr_fetch_unit #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [31:0]       NOP_INSTR   = riscv_pkg::NOP_INSTR,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_go,
  input  logic                instr_ack,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   pc_load_val,
  instr_fetch_unit_if.master  mem,
  output logic                instr_valid,
  output logic [31:0]         ir,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   pc_ir,
  output logic [6:0]          opcode,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic [31:0]         imm,
  output logic                fetch_err
);

  import riscv_pkg::*;

  fetch_state_t state, state_next;
  logic capture, pc_take, timeout, timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= F_IDLE;
      pc    <= RESET_PC;
      pc_ir <= RESET_PC;
      ir    <= NOP_INSTR;
    end else begin
      state <= state_next;
      if (capture) begin
        ir    <= mem.mem_rdata;
        pc_ir <= pc;
        pc    <= pc + ADDR_W'(4);
      end else if (pc_take) begin
        pc <= pc_load_val & ~ADDR_W'(3);
      end
      if (timeout) ir <= NOP_INSTR;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    pc_take    = 1'b0;
    timeout    = 1'b0;
    case (state)
      F_IDLE: begin
        pc_take = pc_load;
        if (fetch_go) state_next = F_REQ;
      end
      F_REQ: state_next = F_WAIT;
      F_WAIT: begin
        if (mem.mem_rvalid) begin
          capture    = 1'b1;
          state_next = F_HOLD;
        end else if (timeout_hit) begin
          timeout    = 1'b1;
          state_next = F_HOLD;
        end
      end
      F_HOLD: begin
        pc_take = pc_load;
        if (instr_ack) state_next = fetch_go ? F_REQ : F_IDLE;
      end
      default: state_next = F_IDLE;
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;

  // wait_cnt equals the number of completed F_WAIT cycles, so the match fires in the last allowed one.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || state != F_WAIT) wait_cnt <= '0;
    else if (!mem.mem_rvalid)   wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                              fetch_err <= 1'b0;
    else if (timeout)                     fetch_err <= 1'b1;
    else if (state == F_HOLD && instr_ack) fetch_err <= 1'b0;
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  assign mem.mem_rd   = (state == F_REQ);
  assign mem.mem_addr = pc;
  assign instr_valid  = (state == F_HOLD);

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  imm_gen u_imm_gen (
    .ir  (ir),
    .imm (imm)
  );

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage that sits directly upstream of the multicycle control FSM.
- Owns the PC.
- Issues single-word instruction reads to the instruction memory over a request/valid handshake.
- Latches the returned word into the instruction register (IR).
- Presents the IR plus decoded fields (opcode, registers, funct, sign-extended immediate) to the controller.
- The controller starts each fetch with fetch_go and consumes the instruction with instr_ack; it redirects the PC for branches with pc_load.

Parameters:
- ADDR_W, 32, PC and memory address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, IR value after reset or fetch error (addi x0,x0,0).
- TIMEOUT_CYC, 16, WAIT-state cycle limit; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- fetch_go  in  1  controller requests the next fetch.
- instr_ack  in  1  controller has consumed the current instruction.
- pc_load  in  1  load PC from pc_load_val (branch/jump).
- pc_load_val  in  ADDR_W  new PC value.
- mem_rd  out  1  read strobe to instruction memory.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  32  read data.
- mem_rvalid  in  1  mem_rdata valid.
- instr_valid  out  1  IR holds a fetched instruction.
- ir  out  32  instruction register.
- pc  out  ADDR_W  next fetch address.
- pc_ir  out  ADDR_W  address the current IR was fetched from.
- opcode  out  7  ir[6:0].
- rd  out  5  ir[11:7].
- rs1  out  5  ir[19:15].
- rs2  out  5  ir[24:20].
- funct3  out  3  ir[14:12].
- funct7  out  7  ir[31:25].
- imm  out  32  sign-extended immediate.
- fetch_err  out  1  fetch timed out.

Behaviour:
- One clock. Reset is synchronous and active-high: clk and rst, rst sampled on rising clk.
- Reset values:
  - State F_IDLE.
  - pc=RESET_PC, pc_ir=RESET_PC, ir=NOP_INSTR.
  - mem_rd=0, mem_addr=RESET_PC.
  - instr_valid=0, fetch_err=0.
- States: F_IDLE, F_REQ, F_WAIT, F_HOLD.
  - F_IDLE: if fetch_go, go to F_REQ.
  - F_REQ: mem_rd=1 for exactly this cycle, mem_addr=pc. Unconditionally go to F_WAIT. mem_rvalid is ignored in this state; memory latency is at least 1 cycle.
  - F_WAIT: mem_addr is held. On mem_rvalid:
    - ir<=mem_rdata, pc_ir<=pc, pc<=pc+4 (wraps modulo 2^ADDR_W).
    - Go to F_HOLD.
  - F_HOLD: instr_valid=1, ir stable.
    - instr_ack alone: go to F_IDLE.
    - instr_ack and fetch_go in the same cycle: go straight to F_REQ (back-to-back fetch).
- Fetch latency: fetch_go to instr_valid is 2 cycles plus memory latency (minimum 3).
- instr_valid is registered, so it rises the cycle after rvalid is captured. It falls the cycle after instr_ack.
- pc_load:
  - Honoured only in F_IDLE and F_HOLD. Sets pc<=pc_load_val with bits [1:0] forced to 0.
  - Ignored in F_REQ and F_WAIT; the controller must not assert it there.
  - If pc_load and a back-to-back fetch occur in the same cycle, F_REQ uses the loaded PC.
- fetch_go outside F_IDLE and F_HOLD is ignored.
- Decoded fields are combinational from ir only; the immediate is selected by opcode:
  - I (0010011, 0000011, 1100111): ir[31:20].
  - S (0100011): {ir[31:25], ir[11:7]}.
  - SB (1100011): {ir[31], ir[7], ir[30:25], ir[11:8], 0}.
  - U (0110111, 0010111): {ir[31:12], 12'b0}.
  - UJ (1101111): {ir[31], ir[19:12], ir[20], ir[30:21], 0}.
  - R and unknown opcodes: 0.
  - All immediates are sign-extended from their top bit.
- Reset mid-fetch: rst in any state returns to reset values next cycle. A late mem_rvalid arriving in F_IDLE is ignored.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter clears on entering F_WAIT and increments each F_WAIT cycle without mem_rvalid.
  - When it reaches TIMEOUT_CYC: ir<=NOP_INSTR, pc is not incremented, fetch_err<=1, go to F_HOLD.
  - fetch_err stays high with instr_valid until instr_ack.
  - mem_rvalid and timeout in the same cycle: rvalid wins.
- Undefined: fetch_err is tied 0, the block waits in F_WAIT indefinitely, and no counter is synthesised.

Decomposition:
- Shared package riscv_pkg holds:
  - Opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL.
  - NOP_INSTR.
  - Fetch-state enum typedef fetch_state_t.
  - The controller adopts the same opcode constants.
- One sub-module, imm_gen: combinational ir to imm.

Test Plan:
1. Reset, then fetch_go with memory returning 32'h00500093 after 1 cycle. Required: mem_rd pulse at addr 0; instr_valid at cycle 3; ir=32'h00500093; opcode=0010011; rd=1; imm=5; pc=4; pc_ir=0.
2. Memory latency 4 cycles. Required: mem_rd high for exactly 1 cycle; mem_addr stable through F_WAIT; instr_valid at cycle 6.
3. In F_HOLD, instr_ack+fetch_go+pc_load with pc_load_val=32'h0000_0103. Required: next mem_addr=32'h0000_0100; no F_IDLE cycle.
4. Branch word 32'hFE000EE3. Required: imm=32'hFFFF_FFFC. Store 32'hFE112E23: imm=32'hFFFF_FFFC. LUI 32'h12345037: imm=32'h1234_5000.
5. rst asserted in F_WAIT, then mem_rvalid arrives the next cycle. Required: ir stays NOP_INSTR, instr_valid=0, pc=RESET_PC.
6. With FETCH_TIMEOUT_EN, no rvalid. Required: after 16 F_WAIT cycles, fetch_err=1, instr_valid=1, ir=NOP_INSTR, pc unchanged; both clear one cycle after instr_ack.
